// File: rtl/addsub_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// addsub_seq : multi-cycle two's-complement adder/subtractor, CHUNK bits/clk,
//              with accumulate mode and carry/overflow/zero status flags.
// Revision   : 1.0
// ---------------------------------------------------------------------------
module addsub_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             acc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;

  // op_a doubles as the partial-result register: as its operand bits are
  // consumed from the bottom, finished sum chunks are shifted in at the top.
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] op_a_nxt;
  logic [WIDTH-1:0] op_b_nxt;
  logic             a_msb;
  logic             b_msb;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [CHUNK:0]   chunk_sum;
  logic             accept;
  logic             last;

  assign accept = (state == IDLE) && start;
  assign last   = (state == RUN) && (cnt == LAST_CNT);
  assign busy   = (state == RUN);

  always_comb begin
    chunk_sum = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]}
              + {{CHUNK{1'b0}}, carry};
  end

  generate
    if (CHUNK < WIDTH) begin : g_multi
      assign op_a_nxt = {chunk_sum[CHUNK-1:0], op_a[WIDTH-1:CHUNK]};
      assign op_b_nxt = {{CHUNK{1'b0}}, op_b[WIDTH-1:CHUNK]};
    end else begin : g_single
      assign op_a_nxt = chunk_sum[CHUNK-1:0];
      assign op_b_nxt = op_b;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (cnt == LAST_CNT) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_a  <= acc ? s : a;
        op_b  <= sub ? ~b : b;
        a_msb <= acc ? s[WIDTH-1] : a[WIDTH-1];
        b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
        carry <= sub;
        cnt   <= '0;
      end else if (state == RUN) begin
        op_a  <= op_a_nxt;
        op_b  <= op_b_nxt;
        carry <= chunk_sum[CHUNK];
        cnt   <= cnt + 1'b1;
        if (last) begin
          s    <= op_a_nxt;
          cout <= chunk_sum[CHUNK];
          ovf  <= (a_msb == b_msb) && (op_a_nxt[WIDTH-1] != a_msb);
          zero <= (op_a_nxt == '0);
          done <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_addsub_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_addsub_seq : self-checking bench for addsub_seq (8/2, 4/1 and 4/4).
// Revision      : 1.0
// ---------------------------------------------------------------------------
module tb_addsub_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start_v = 3'b000;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic       sub_in = 1'b0;
  logic       acc_in = 1'b0;

  logic [2:0] busy_v, done_v, cout_v, ovf_v, zero_v;
  logic [7:0] s8;
  logic [3:0] s41, s44;

  int checks = 0;
  int failures = 0;
  logic [7:0] s_model [3];

  always #5 clk = ~clk;

  addsub_seq #(.WIDTH(8), .CHUNK(2)) u_w8c2 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_in), .b(b_in),
    .sub(sub_in), .acc(acc_in), .busy(busy_v[0]), .done(done_v[0]),
    .s(s8), .cout(cout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0]));

  addsub_seq #(.WIDTH(4), .CHUNK(1)) u_w4c1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_in[3:0]), .b(b_in[3:0]),
    .sub(sub_in), .acc(acc_in), .busy(busy_v[1]), .done(done_v[1]),
    .s(s41), .cout(cout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1]));

  addsub_seq #(.WIDTH(4), .CHUNK(4)) u_w4c4 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a_in[3:0]), .b(b_in[3:0]),
    .sub(sub_in), .acc(acc_in), .busy(busy_v[2]), .done(done_v[2]),
    .s(s44), .cout(cout_v[2]), .ovf(ovf_v[2]), .zero(zero_v[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] s_of(input int idx);
    if (idx == 0) return s8;
    if (idx == 1) return {4'h0, s41};
    return {4'h0, s44};
  endfunction

  function automatic int width_of(input int idx);
    return (idx == 0) ? 8 : 4;
  endfunction

  function automatic int nchunk_of(input int idx);
    return (idx == 0) ? 4 : ((idx == 1) ? 4 : 1);
  endfunction

  // Reference: plain integer arithmetic. Returns {cout, ovf, zero, s[7:0]}.
  function automatic logic [10:0] model(input int w, input logic [7:0] x,
                                        input logic [7:0] y, input logic sb);
    int mask, ux, uy, sx, sy, ures, sres, r;
    logic c, o;
    mask = (1 << w) - 1;
    ux = int'(x) & mask;
    uy = int'(y) & mask;
    sx = (ux >= (1 << (w - 1))) ? ux - (1 << w) : ux;
    sy = (uy >= (1 << (w - 1))) ? uy - (1 << w) : uy;
    ures = sb ? ux - uy : ux + uy;
    sres = sb ? sx - sy : sx + sy;
    r = ures & mask;
    c = sb ? (ux >= uy) : (ux + uy > mask);
    o = (sres > (1 << (w - 1)) - 1) || (sres < -(1 << (w - 1)));
    return {c, o, (r == 0), 8'(r)};
  endfunction

  // Caller is positioned at a negedge; returns at the negedge where DONE is seen.
  task automatic run_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                        input logic sb, input logic ac, input string tag);
    logic [7:0]  opa;
    logic [10:0] exp;
    int k, busy_cnt;
    a_in = a; b_in = b; sub_in = sb; acc_in = ac;
    start_v[idx] = 1'b1;
    opa = ac ? s_model[idx] : a;
    exp = model(width_of(idx), opa, b, sb);
    k = 0; busy_cnt = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      start_v[idx] = 1'b0;
      if (done_v[idx]) break;
      if (busy_v[idx]) busy_cnt++;
    end
    if (!done_v[idx]) chk({tag, "_timeout"}, 32'd0, 32'd1);
    chk({tag, "_lat"}, k - 1, nchunk_of(idx));
    chk({tag, "_busy"}, busy_cnt, nchunk_of(idx));
    chk({tag, "_s"}, s_of(idx), exp[7:0]);
    chk({tag, "_cout"}, cout_v[idx], exp[10]);
    chk({tag, "_ovf"}, ovf_v[idx], exp[9]);
    chk({tag, "_zero"}, zero_v[idx], exp[8]);
    s_model[idx] = exp[7:0];
  endtask

  initial begin
    int k, ndone;
    for (int i = 0; i < 3; i++) s_model[i] = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_s", s_of(i), 8'h00);
      chk("rst_flags", {busy_v[i], done_v[i], cout_v[i], ovf_v[i], zero_v[i]}, 5'b0);
    end

    run_op(0, 8'd10, 8'd3, 1'b0, 1'b0, "add10_3");
    run_op(0, 8'd10, 8'd3, 1'b1, 1'b0, "sub10_3");
    chk("sub10_3_val", s8, 8'd7);
    run_op(0, 8'd3, 8'd10, 1'b1, 1'b0, "sub3_10");
    chk("sub3_10_val", s8, 8'hF9);
    run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, "add7f_1");
    chk("add7f_1_ovf", ovf_v[0], 1'b1);
    run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, "addff_1");
    chk("addff_1_zero", {cout_v[0], zero_v[0]}, 2'b11);
    run_op(0, 8'h80, 8'h01, 1'b1, 1'b0, "sub80_1");
    chk("sub80_1_val", {ovf_v[0], s8}, {1'b1, 8'h7F});

    // Accumulate chain, each START raised in the DONE cycle.
    run_op(0, 8'd9, 8'd0, 1'b0, 1'b0, "acc0");
    for (int i = 0; i < 3; i++) begin
      run_op(0, 8'hAA, 8'd1, 1'b0, 1'b1, "acc");
      chk("acc_val", s8, 8'(10 + i));
    end
    @(negedge clk);

    // Randomized mix, including accumulate and back-to-back issue.
    for (int i = 0; i < 40; i++)
      run_op(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), "rnd8");
    @(negedge clk);

    for (int idx = 1; idx < 3; idx++) begin
      run_op(idx, 8'd10, 8'd3, 1'b0, 1'b0, "w4_add");
      chk("w4_add_val", {cout_v[idx], s_of(idx)}, {1'b0, 8'd13});
      run_op(idx, 8'd9, 8'd1, 1'b1, 1'b0, "w4_sub");
      chk("w4_sub_val", {cout_v[idx], s_of(idx)}, {1'b1, 8'd8});
      run_op(idx, 8'd9, 8'd1, 1'b0, 1'b0, "w4_inc");
      chk("w4_inc_val", s_of(idx), 8'd10);
      for (int i = 0; i < 20; i++)
        run_op(idx, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), "rnd4");
      @(negedge clk);
    end

    // Operand changes and a START pulse during RUN must not disturb the op.
    a_in = 8'h20; b_in = 8'h05; sub_in = 1'b0; acc_in = 1'b0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b1;
    a_in = 8'hFF; b_in = 8'hFF; sub_in = 1'b1; acc_in = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) start_v[0] = 1'b0;
      if (done_v[0]) begin
        ndone++;
        chk("midrun_s", s8, 8'h25);
      end
    end
    chk("midrun_ndone", ndone, 1);

    // Reset while cnt == 2 aborts the operation.
    a_in = 8'h01; b_in = 8'h01; sub_in = 1'b0; acc_in = 1'b0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_s", s8, 8'h00);
    chk("abort_flags", {busy_v[0], done_v[0], cout_v[0], ovf_v[0], zero_v[0]}, 5'b0);
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_v[0]) k++;
    end
    chk("abort_nodone", k, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
